// File: rtl/spdif_subframe_assembler.sv
// S/PDIF subframe assembler: frames 28 decoded time slots into sample + V/U/C/P.
// Latency: sample_valid rises on the clk edge that registers the 28th bit strobe.
// Backpressure: none; a one-cycle sample_valid pulse per subframe, no stall input.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   enable                0 holds the block in IDLE, outputs keep their value
//   bit_data, bit_clk     recovered bit stream from the biphase-mark decoder
//   preamble, preamble_type  one-cycle preamble pulse and its type (B/M/W/illegal)
//   sample .. chan_status    decoded subframe fields, parity_err, channel
//   sample_valid, block_start, frame_idx, sync_err  framing status
// Optional: define SPDIF_CHSTAT_CAPTURE_EN to add cs_word/cs_valid, a 32-bit
//   capture of the left-channel C bits of frames 0..31 of each block.
module spdif_subframe_assembler #(
  parameter int BLOCK_LEN = 192,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        bit_data,
  input  logic        bit_clk,
  input  logic        preamble,
  input  logic [1:0]  preamble_type,
  output logic [23:0] sample,
  output logic        channel,
  output logic        validity,
  output logic        user,
  output logic        chan_status,
  output logic        parity_err,
  output logic        sample_valid,
  output logic        block_start,
  output logic [7:0]  frame_idx,
`ifdef SPDIF_CHSTAT_CAPTURE_EN
  output logic [31:0] cs_word,
  output logic        cs_valid,
`endif
  output logic        sync_err
);

  localparam int              WDW      = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WDOG_MAX = WDW'(TIMEOUT - 1);
  localparam logic [7:0]      LAST_IDX = 8'(BLOCK_LEN - 1);
  localparam logic [1:0]      PT_B     = 2'd0;
  localparam logic [1:0]      PT_M     = 2'd1;
  localparam logic [1:0]      PT_W     = 2'd2;
  localparam logic [1:0]      PT_BAD   = 2'd3;

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  state_t         state;
  logic           bit_clk_q;
  logic [4:0]     cnt;
  logic [WDW-1:0] wdog;
  logic [26:0]    shreg;        // slots 0..26; slot 27 comes straight from bit_data
  logic [1:0]     ptype;
  logic           pend_vld;     // preamble that arrived with the final strobe
  logic [1:0]     pend_type;
  logic           block_locked;

  logic           strobe;
  logic [27:0]    full;
  logic           emit_pre;
  logic [1:0]     emit_type;
  logic [7:0]     idx_nxt;
  logic           locked_nxt;
  logic           miss_b;

  assign strobe    = bit_clk & ~bit_clk_q & enable;
  assign full      = {bit_data, shreg};
  // A live preamble in EMIT is newer than a buffered one, so it wins.
  assign emit_pre  = preamble | pend_vld;
  assign emit_type = preamble ? preamble_type : pend_type;

  // Block position after the subframe being completed.
  always_comb begin
    idx_nxt    = frame_idx;
    locked_nxt = block_locked;
    miss_b     = 1'b0;
    case (ptype)
      PT_B: begin
        idx_nxt    = 8'd0;
        locked_nxt = 1'b1;
      end
      PT_M: begin
        if (frame_idx == LAST_IDX) begin
          idx_nxt = 8'd0;
          if (block_locked) begin
            miss_b     = 1'b1;
            locked_nxt = 1'b0;
          end
        end else begin
          idx_nxt = frame_idx + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_clk_q    <= 1'b0;
      cnt          <= 5'd0;
      wdog         <= '0;
      shreg        <= '0;
      ptype        <= PT_B;
      pend_vld     <= 1'b0;
      pend_type    <= PT_B;
      block_locked <= 1'b0;
      sample       <= '0;
      channel      <= 1'b0;
      validity     <= 1'b0;
      user         <= 1'b0;
      chan_status  <= 1'b0;
      parity_err   <= 1'b0;
      sample_valid <= 1'b0;
      block_start  <= 1'b0;
      frame_idx    <= 8'd0;
      sync_err     <= 1'b0;
`ifdef SPDIF_CHSTAT_CAPTURE_EN
      cs_word      <= '0;
      cs_valid     <= 1'b0;
`endif
    end else begin
      bit_clk_q    <= bit_clk;
      sample_valid <= 1'b0;
      block_start  <= 1'b0;
      sync_err     <= 1'b0;
`ifdef SPDIF_CHSTAT_CAPTURE_EN
      cs_valid     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          pend_vld <= 1'b0;
          if (enable && preamble) begin
            if (preamble_type == PT_BAD) begin
              sync_err <= 1'b1;
            end else begin
              ptype <= preamble_type;
              cnt   <= 5'd0;
              wdog  <= '0;
              state <= COLLECT;
            end
          end
        end

        COLLECT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (strobe && cnt == 5'd27) begin
            // Final slot: register every subframe output on this edge.
            sample       <= full[23:0];
            validity     <= full[24];
            user         <= full[25];
            chan_status  <= full[26];
            parity_err   <= ^full;
            channel      <= (ptype == PT_W);
            sample_valid <= 1'b1;
            block_start  <= (ptype == PT_B);
            frame_idx    <= idx_nxt;
            block_locked <= locked_nxt;
            if (miss_b) sync_err <= 1'b1;
`ifdef SPDIF_CHSTAT_CAPTURE_EN
            if (ptype != PT_W && idx_nxt < 8'd32) cs_word[idx_nxt[4:0]] <= full[26];
            if (ptype != PT_W && idx_nxt == 8'd31 && locked_nxt) cs_valid <= 1'b1;
`endif
            // The next subframe's preamble may coincide with our last strobe.
            pend_vld  <= preamble;
            pend_type <= preamble_type;
            state     <= EMIT;
          end else if (preamble) begin
            sync_err <= 1'b1;
            if (preamble_type == PT_BAD) begin
              state <= IDLE;
            end else begin
              ptype <= preamble_type;
              cnt   <= 5'd0;
              wdog  <= '0;
            end
          end else if (strobe) begin
            shreg[cnt] <= bit_data;
            cnt        <= cnt + 5'd1;
            wdog       <= '0;
          end else if (wdog == WDOG_MAX) begin
            sync_err <= 1'b1;
            state    <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        EMIT: begin
          // Outputs were registered on entry; handle any buffered preamble here
          // exactly as IDLE would, so its first bit strobe is not missed.
          pend_vld <= 1'b0;
          state    <= IDLE;
          if (enable && emit_pre) begin
            if (emit_type == PT_BAD) begin
              sync_err <= 1'b1;
            end else begin
              ptype <= emit_type;
              cnt   <= 5'd0;
              wdog  <= '0;
              state <= COLLECT;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
